// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier.
// Retires one Booth digit per clock and supports signed and unsigned operands.
// Operands are extended by two bits, so NDIG = WIDTH/2 + 1 digits give an exact
// product. The low 2*WIDTH bits of that product are presented on result.
module booth_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cancel,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [ACCW-1:0]      acc_r;
  logic [ACCW-1:0]      mcand_r;   // extended multiplicand, pre-weighted by 4^i
  logic [WIDTH+2:0]     mplier_r;  // {extended multiplier, b[-1]}, shifted 2 per digit
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   result_r;

  logic [2:0]           dig_s;     // {negate, double, single}
  logic [ACCW-1:0]      pp_s;
  logic [ACCW-1:0]      addend_s;
  logic [ACCW-1:0]      acc_next_s;
  logic                 ext_a_s;
  logic                 ext_b_s;

  // Map a Booth triplet to {negate, 2A, 1A} selects.
  function automatic logic [2:0] booth_dec(input logic [2:0] trip);
    logic [2:0] sel;
    case (trip)
      3'b000, 3'b111: sel = 3'b000;
      3'b001, 3'b010: sel = 3'b001;
      3'b011:         sel = 3'b010;
      3'b100:         sel = 3'b110;
      3'b101, 3'b110: sel = 3'b101;
      default:        sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Choose the partial product. A negative digit is added as its inverse plus a carry-in.
  always_comb begin
    dig_s = booth_dec(mplier_r[2:0]);
    if (dig_s[1]) begin
      pp_s = {mcand_r[ACCW-2:0], 1'b0};
    end else if (dig_s[0]) begin
      pp_s = mcand_r;
    end else begin
      pp_s = {ACCW{1'b0}};
    end
    if (dig_s[2]) begin
      addend_s = ~pp_s;
    end else begin
      addend_s = pp_s;
    end
    acc_next_s = acc_r + addend_s + {{(ACCW-1){1'b0}}, dig_s[2]};
  end

  // Compute the operand extension bits: sign extension in signed mode, zero otherwise.
  always_comb begin
    if (sign) begin
      ext_a_s = a[WIDTH-1];
      ext_b_s = b[WIDTH-1];
    end else begin
      ext_a_s = 1'b0;
      ext_b_s = 1'b0;
    end
  end

  // Control FSM, digit iteration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {ACCW{1'b0}};
      mcand_r  <= {ACCW{1'b0}};
      mplier_r <= {(WIDTH+3){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !cancel) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {ACCW{1'b0}};
            mcand_r  <= {{(ACCW-WIDTH){ext_a_s}}, a};
            mplier_r <= {ext_b_s, ext_b_s, b, 1'b0};
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[ACCW-3:0], 2'b00};
            mplier_r <= {{2{mplier_r[WIDTH+2]}}, mplier_r[WIDTH+2:2]};
            if (cnt_r == LAST_DIG) begin
              state_r  <= IDLE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              result_r <= acc_next_s[2*WIDTH-1:0];
            end else begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter (WIDTH=32).
// Expected products are computed with native 64-bit arithmetic.
module tb_booth_mul_iter;

  localparam int W    = 32;
  localparam int NDIG = W / 2 + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          cancel;
  logic          sign;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;

  int total;
  int bad;
  logic [63:0] last_res;

  booth_mul_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .sign(sign),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end else begin
      ux = {32'd0, x};
      uy = {32'd0, y};
      return 64'(ux * uy);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Start an operation at the current negedge and follow it to completion.
  // The caller is left at the negedge on which done is visible.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] exp;
    int n;
    exp = ref_mul(s, x, y);
    sign = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    sign = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    check({tag, "_acc_busy"}, 64'(busy), 64'd1);
    check({tag, "_acc_done"}, 64'(done), 64'd0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 8 && done !== 1'b1) check({tag, "_hold"}, result, last_res);
    end
    check({tag, "_latency"}, 64'(n), 64'(NDIG));
    check({tag, "_result"}, result, exp);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    last_res = exp;
  endtask

  initial begin
    int ndone, done_edge, busy_err;
    total = 0; bad = 0; last_res = 64'd0;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; sign = 1'b0; a = 32'd0; b = 32'd0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;
    tick();

    // Directed corners.
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s_m1m1");
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_maxmax");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, "s_minmin");
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, "s_min1");
    check("lit_s_min1", last_res, 64'hFFFF_FFFF_8000_0000);

    // start while busy: 3*5 accepted, 7*7 pulsed on the 5th RUN edge.
    tick();
    sign = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; done_edge = 0; busy_err = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) begin
        start = 1'b1; a = 32'd7; b = 32'd7;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        done_edge = e;
      end
      if (busy !== ((e < NDIG) ? 1'b1 : 1'b0)) busy_err++;
    end
    check("sb_done_cnt", 64'(ndone), 64'd1);
    check("sb_done_edge", 64'(done_edge), 64'(NDIG));
    check("sb_result", result, 64'd15);
    check("sb_busy_pattern", 64'(busy_err), 64'd0);
    last_res = 64'd15;

    // A previous result that differs from the cancelled product.
    do_op(1'b1, 32'hFFFF_FFF9, 32'd9, "pre_cancel");

    // Cancel on the 8th RUN edge.
    sign = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e < 8; e++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cx_busy", 64'(busy), 64'd0);
    check("cx_done", 64'(done), 64'd0);
    check("cx_result", result, last_res);
    tick();
    check("cx_idle_done", 64'(done), 64'd0);
    do_op(1'b1, 32'd123, 32'hFFFF_FF00, "after_cx");

    // Cancel on the completion edge: cancel wins.
    tick();
    sign = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e < NDIG; e++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cxlast_busy", 64'(busy), 64'd0);
    check("cxlast_done", 64'(done), 64'd0);
    check("cxlast_result", result, last_res);

    // Cancel beats start in IDLE.
    start = 1'b1; cancel = 1'b1; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cx_prio_busy", 64'(busy), 64'd0);
    tick();
    check("cx_prio_done", 64'(done), 64'd0);

    // Reset asserted just after the 10th RUN edge.
    sign = 1'b1; a = 32'd1000; b = 32'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e < 10; e++) tick();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_result", result, 64'd0);
    @(negedge clk);
    tick();
    check("mr_hold_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    last_res = 64'd0;
    do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "post_rst");

    // Random back-to-back operations, each started on the done cycle.
    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), "rand");
    end
    tick();
    check("end_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
